// File: rtl/execute_cc.sv
`default_nettype none
//============================================================================
// Module      : execute_cc
// Description : Y86-64 SEQ execute stage. Selects the ALU operands from
//               valA/valB/valC, computes valE, holds the ZF/SF/OF condition
//               code register, evaluates Cnd for cmovXX/jXX from the
//               registered CC, and tracks a sticky AOK/HLT/INS status.
// Ports       : clk      - rising-edge clock
//               rst_n    - synchronous reset, active-low
//               en       - instruction valid / advance (0 = stall)
//               icode    - instruction code
//               ifun     - function code (ALU op or condition)
//               valA     - operand from decode
//               valB     - operand from decode
//               valC     - immediate / displacement from fetch
//               valE     - ALU result (combinational)
//               Cnd      - condition outcome (combinational, from CC)
//               zf/sf/of - registered condition-code flags
//               stat     - registered status (0 AOK, 1 HLT, 2 INS)
// Revision    : 1.0 - initial release
//============================================================================
module execute_cc #(
    parameter int WIDTH     = 64,
    parameter int STACK_INC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic [WIDTH-1:0] valE,
    output logic             Cnd,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic [1:0]       stat
);

    // Instruction codes
    localparam logic [3:0] c_I_HALT   = 4'h0;
    localparam logic [3:0] c_I_CMOVXX = 4'h2;
    localparam logic [3:0] c_I_IRMOVQ = 4'h3;
    localparam logic [3:0] c_I_RMMOVQ = 4'h4;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_CALL   = 4'h8;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_PUSHQ  = 4'hA;
    localparam logic [3:0] c_I_POPQ   = 4'hB;
    localparam logic [3:0] c_I_FIRST_BAD = 4'hC;

    // ALU function codes for OPq
    localparam logic [3:0] c_ALU_ADD = 4'h0;
    localparam logic [3:0] c_ALU_SUB = 4'h1;
    localparam logic [3:0] c_ALU_AND = 4'h2;
    localparam logic [3:0] c_ALU_XOR = 4'h3;

    // Stack step and its two's complement negation
    localparam logic [WIDTH-1:0] c_STACK_POS = WIDTH'(STACK_INC);
    localparam logic [WIDTH-1:0] c_STACK_NEG = ~c_STACK_POS + {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_AOK = 2'd0,
        ST_HLT = 2'd1,
        ST_INS = 2'd2
    } stat_t;

    stat_t            r_state;
    stat_t            w_state_next;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;

    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [WIDTH-1:0] w_res;
    logic             w_new_of;
    logic             w_is_opq;
    logic             w_is_cond;
    logic             w_opq_bad;
    logic             w_cond_bad;
    logic             w_invalid;
    logic             w_cc_load;
    logic             w_cnd;

    assign w_is_opq   = (icode == c_I_OPQ);
    assign w_is_cond  = (icode == c_I_CMOVXX) || (icode == c_I_JXX);
    assign w_opq_bad  = w_is_opq  && (ifun > c_ALU_XOR);
    assign w_cond_bad = w_is_cond && (ifun > 4'h6);
    assign w_invalid  = (icode >= c_I_FIRST_BAD) || w_opq_bad || w_cond_bad;

    //------------------------------------------------------------------------
    // Operand selection
    //------------------------------------------------------------------------
    always_comb begin
        w_alu_a = '0;
        case (icode)
            c_I_CMOVXX, c_I_OPQ:                 w_alu_a = valA;
            c_I_IRMOVQ, c_I_RMMOVQ, c_I_MRMOVQ:  w_alu_a = valC;
            c_I_CALL,   c_I_PUSHQ:               w_alu_a = c_STACK_NEG;
            c_I_RET,    c_I_POPQ:                w_alu_a = c_STACK_POS;
            default:                             w_alu_a = '0;
        endcase
    end

    always_comb begin
        w_alu_b = '0;
        case (icode)
            c_I_RMMOVQ, c_I_MRMOVQ, c_I_OPQ,
            c_I_CALL,   c_I_RET,    c_I_PUSHQ, c_I_POPQ: w_alu_b = valB;
            default:                                     w_alu_b = '0;
        endcase
    end

    //------------------------------------------------------------------------
    // ALU and overflow detection. Only OPq honours ifun; every other icode
    // uses the adder, so its overflow term is irrelevant (CC never loads).
    //------------------------------------------------------------------------
    always_comb begin
        w_res    = w_alu_b + w_alu_a;
        w_new_of = 1'b0;
        if (w_is_opq) begin
            case (ifun)
                c_ALU_ADD: begin
                    w_res    = w_alu_b + w_alu_a;
                    w_new_of = (w_alu_a[WIDTH-1] == w_alu_b[WIDTH-1]) &&
                               (w_res[WIDTH-1]   != w_alu_a[WIDTH-1]);
                end
                c_ALU_SUB: begin
                    w_res    = w_alu_b - w_alu_a;
                    w_new_of = (w_alu_b[WIDTH-1] != w_alu_a[WIDTH-1]) &&
                               (w_res[WIDTH-1]   != w_alu_b[WIDTH-1]);
                end
                c_ALU_AND: w_res = w_alu_b & w_alu_a;
                c_ALU_XOR: w_res = w_alu_b ^ w_alu_a;
                default:   w_res = '0;
            endcase
        end
    end

    assign valE = w_res;

    //------------------------------------------------------------------------
    // Condition evaluation from the registered flags only, so Cnd never sees
    // the flags produced by the instruction currently in execute.
    //------------------------------------------------------------------------
    always_comb begin
        w_cnd = 1'b0;
        if (w_is_cond) begin
            case (ifun)
                4'h0:    w_cnd = 1'b1;
                4'h1:    w_cnd = (r_sf ^ r_of) | r_zf;
                4'h2:    w_cnd = r_sf ^ r_of;
                4'h3:    w_cnd = r_zf;
                4'h4:    w_cnd = ~r_zf;
                4'h5:    w_cnd = ~(r_sf ^ r_of);
                4'h6:    w_cnd = ~(r_sf ^ r_of) & ~r_zf;
                default: w_cnd = 1'b0;
            endcase
        end
    end

    assign Cnd = w_cnd;

    //------------------------------------------------------------------------
    // Status state machine: HLT and INS are terminal until reset.
    //------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_AOK: begin
                if (en) begin
                    if (icode == c_I_HALT) begin
                        w_state_next = ST_HLT;
                    end else if (w_invalid) begin
                        w_state_next = ST_INS;
                    end
                end
            end
            ST_HLT:  w_state_next = ST_HLT;
            ST_INS:  w_state_next = ST_INS;
            default: w_state_next = ST_INS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_AOK;
        end else begin
            r_state <= w_state_next;
        end
    end

    //------------------------------------------------------------------------
    // Condition-code register. A bad OPq function never loads the flags.
    //------------------------------------------------------------------------
    assign w_cc_load = en && w_is_opq && !w_opq_bad && (r_state == ST_AOK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_cc_load) begin
            r_zf <= (w_res == '0);
            r_sf <= w_res[WIDTH-1];
            r_of <= w_new_of;
        end
    end

    assign zf   = r_zf;
    assign sf   = r_sf;
    assign of   = r_of;
    assign stat = r_state;

endmodule
`default_nettype wire
